// File: rtl/ami_req_arbiter.sv
// Round-robin arbiter sharing one AMI request/response channel among NUM_REQ requesters.
// Optional orphan-response detection is enabled by defining AMI_ARB_ERR_EN.

package ami_arb_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  size;
    } ami_request_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  size;
    } ami_response_t;
endpackage

module ami_req_arbiter
    import ami_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int REQ_ID_W        = $clog2(NUM_REQ),
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  ami_request_t  [NUM_REQ-1:0]   req_in,
    output logic          [NUM_REQ-1:0]   req_in_grant,
    output ami_response_t [NUM_REQ-1:0]   resp_out,
    input  logic          [NUM_REQ-1:0]   resp_out_grant,
    output ami_request_t                  req_out,
    input  logic                          req_out_grant,
    input  ami_response_t                 resp_in,
    output logic                          resp_in_grant,
    output logic          [CNT_W-1:0]     outstanding
`ifdef AMI_ARB_ERR_EN
    ,
    output logic                          err_orphan
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [REQ_ID_W-1:0] tag_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [REQ_ID_W-1:0] rr_ptr_r;
    logic [REQ_ID_W-1:0] winner_s;
    logic [REQ_ID_W-1:0] idx_s;
    logic [REQ_ID_W-1:0] head_s;
    logic [NUM_REQ-1:0]  eligible_s;
    logic                can_load_s;
    logic                found_s;
    logic                grant_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;

    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign head_s       = tag_mem_r[rd_ptr_r];
    assign outstanding  = count_r;

    // Route the in-order response to the owner of the oldest outstanding read.
    always_comb begin
        resp_out      = '0;
        resp_in_grant = 1'b0;
        pop_s         = 1'b0;
        if (!fifo_empty_s && resp_in.valid) begin
            resp_out[head_s] = resp_in;
            resp_in_grant    = resp_out_grant[head_s];
            pop_s            = resp_out_grant[head_s];
        end else begin
`ifdef AMI_ARB_ERR_EN
            // Only an orphan can be valid here; it is swallowed.
            resp_in_grant = resp_in.valid;
`else
            resp_in_grant = 1'b0;
`endif
        end
    end

    // Eligibility and round-robin winner search starting after the last winner.
    always_comb begin
        fifo_full_s = (count_r == FULL_CNT) && !pop_s;
        eligible_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_in[i].valid && (req_in[i].isWrite || !fifo_full_s);
        end
        found_s  = 1'b0;
        winner_s = rr_ptr_r;
        idx_s    = rr_ptr_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = REQ_ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!found_s && eligible_s[idx_s]) begin
                winner_s = idx_s;
            end else begin
                winner_s = winner_s;
            end
            found_s = found_s | eligible_s[idx_s];
        end
        can_load_s   = !req_out.valid || req_out_grant;
        grant_s      = can_load_s && found_s;
        req_in_grant = '0;
        if (grant_s) begin
            req_in_grant[winner_s] = 1'b1;
        end else begin
            req_in_grant = '0;
        end
        push_s = grant_s && !req_in[winner_s].isWrite;
    end

    // Output request register and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_out  <= '0;
            rr_ptr_r <= REQ_ID_W'(NUM_REQ - 1);
        end else if (can_load_s) begin
            if (grant_s) begin
                req_out  <= req_in[winner_s];
                rr_ptr_r <= winner_s;
            end else begin
                req_out <= '0;
            end
        end
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Order FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= winner_s;
        end
    end

`ifdef AMI_ARB_ERR_EN
    // Sticky orphan flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_orphan <= 1'b0;
        end else if (resp_in.valid && fifo_empty_s) begin
            err_orphan <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ami_req_arbiter.sv
// Scoreboard bench for ami_req_arbiter: a queue-based reference model predicts each cycle's
// grants/routing and every accepted request; a separate monitor compares the DUT against it.
module tb_ami_req_arbiter;
    import ami_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 16;
    localparam int CNT_W   = 5;
`ifdef AMI_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic               rig;
        int                 target;
        ami_response_t      resp;
        int                 outst;
        logic               out_valid;
        logic               err;
    } rec_t;

    logic                          clk = 1'b0;
    logic                          reset;
    ami_request_t  [NUM_REQ-1:0]   req_in;
    logic          [NUM_REQ-1:0]   req_in_grant;
    ami_response_t [NUM_REQ-1:0]   resp_out;
    logic          [NUM_REQ-1:0]   resp_out_grant;
    ami_request_t                  req_out;
    logic                          req_out_grant;
    ami_response_t                 resp_in;
    logic                          resp_in_grant;
    logic          [CNT_W-1:0]     outstanding;
    logic                          err_orphan_s;

    ami_req_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .req_in_grant(req_in_grant),
        .resp_out(resp_out), .resp_out_grant(resp_out_grant), .req_out(req_out),
        .req_out_grant(req_out_grant), .resp_in(resp_in), .resp_in_grant(resp_in_grant),
        .outstanding(outstanding)
`ifdef AMI_ARB_ERR_EN
        , .err_orphan(err_orphan_s)
`endif
    );
`ifndef AMI_ARB_ERR_EN
    assign err_orphan_s = 1'b0;
`endif

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    rec_t         rec_q[$];
    ami_request_t exp_req_q[$];
    int           tags[$];
    int           m_rr;
    bit           m_out_full;
    bit           m_err;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_rr       = NUM_REQ - 1;
        m_out_full = 1'b0;
        m_err      = 1'b0;
        tags.delete();
        exp_req_q.delete();
    endfunction

    // Predict this cycle from the current inputs and the model state, then advance the model.
    function automatic void model_step();
        rec_t r;
        bit   can_load, pop, full, has_head;
        int   w, idx;
        has_head    = (tags.size() > 0) && resp_in.valid;
        r.outst     = tags.size();
        r.out_valid = m_out_full;
        r.err       = m_err;
        r.resp      = resp_in;
        r.target    = -1;
        r.rig       = ERR_EN && resp_in.valid && (tags.size() == 0);
        pop         = 1'b0;
        if (has_head) begin
            r.target = tags[0];
            r.rig    = resp_out_grant[tags[0]];
            pop      = resp_out_grant[tags[0]];
        end
        can_load = !m_out_full || req_out_grant;
        full     = (tags.size() == MAX_OUT) && !pop;
        w        = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_rr + k) % NUM_REQ;
            if (w < 0 && req_in[idx].valid && (req_in[idx].isWrite || !full)) w = idx;
        end
        r.grant = '0;
        if (resp_in.valid && tags.size() == 0 && ERR_EN) m_err = 1'b1;
        if (pop) void'(tags.pop_front());
        if (can_load && w >= 0) begin
            r.grant = NUM_REQ'(1) << w;
            if (!req_in[w].isWrite) tags.push_back(w);
            exp_req_q.push_back(req_in[w]);
            m_rr       = w;
            m_out_full = 1'b1;
        end else if (can_load) begin
            m_out_full = 1'b0;
        end
        rec_q.push_back(r);
    endfunction

    task automatic drive_random(input int p_req, input int p_wr, input int p_resp,
                                input int p_rog, input int p_rg);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in[i].valid   = ($urandom_range(0, 99) < p_req);
            req_in[i].isWrite = ($urandom_range(0, 99) < p_wr);
            req_in[i].addr    = $urandom;
            req_in[i].data    = {$urandom, $urandom};
            req_in[i].size    = 8'($urandom);
            resp_out_grant[i] = ($urandom_range(0, 99) < p_rg);
        end
        req_out_grant = ($urandom_range(0, 99) < p_rog);
        resp_in.valid = ($urandom_range(0, 99) < p_resp);
        resp_in.data  = {$urandom, $urandom};
        resp_in.size  = 8'($urandom);
    endtask

    task automatic drive_all_reads();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in[i].valid   = 1'b1;
            req_in[i].isWrite = 1'b0;
            req_in[i].addr    = 32'h1000 + 32'(i);
            req_in[i].data    = 64'(i);
            req_in[i].size    = 8'd8;
        end
        resp_out_grant = '1;
        req_out_grant  = 1'b1;
        resp_in        = '0;
    endtask

    task automatic run_phase(input int n, input int p_req, input int p_wr, input int p_resp,
                             input int p_rog, input int p_rg);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive_random(p_req, p_wr, p_resp, p_rog, p_rg);
            model_step();
        end
    endtask

    // Monitor: compare DUT outputs with the predicted record of the current cycle.
    initial begin
        rec_t         r;
        ami_request_t prev;
        bit           prev_rog;
        bit           have_prev;
        have_prev = 1'b0;
        prev      = '0;
        prev_rog  = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rec_q.size() > 0) begin
                r = rec_q.pop_front();
                chk("req_in_grant", 128'(req_in_grant), 128'(r.grant));
                chk("resp_in_grant", 128'(resp_in_grant), 128'(r.rig));
                chk("outstanding", 128'(outstanding), 128'(r.outst));
                chk("req_out_valid", 128'(req_out.valid), 128'(r.out_valid));
                if (ERR_EN) chk("err_orphan", 128'(err_orphan_s), 128'(r.err));
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j == r.target) chk("resp_out_route", 128'(resp_out[j]), 128'(r.resp));
                    else chk("resp_out_idle", 128'(resp_out[j].valid), 128'(1'b0));
                end
                if (have_prev && prev.valid && !prev_rog)
                    chk("req_out_hold", 128'(req_out), 128'(prev));
                if (req_out.valid && req_out_grant) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_out_unexpected: got %h expected none", req_out);
                    end else begin
                        chk("req_out_data", 128'(req_out), 128'(exp_req_q.pop_front()));
                    end
                end
                prev      = req_out;
                prev_rog  = req_out_grant;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        reset          = 1'b1;
        req_in         = '0;
        resp_out_grant = '0;
        req_out_grant  = 1'b0;
        resp_in        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req_out", 128'(req_out), 128'(0));
        chk("rst_req_in_grant", 128'(req_in_grant), 128'(0));
        chk("rst_resp_in_grant", 128'(resp_in_grant), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_err_orphan", 128'(err_orphan_s), 128'(0));

        // Fairness: all requesters read with no backpressure.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive_all_reads();
            model_step();
        end
        run_phase(300, 70, 20, 10, 80, 70);
        run_phase(300, 30, 30, 80, 80, 80);
        run_phase(800, 60, 40, 50, 60, 60);
        run_phase(200, 80, 10,  5, 90, 70);

        // Mid-operation reset with reads outstanding.
        @(negedge clk);
        req_in = '0;
        resp_in = '0;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_outstanding", 128'(outstanding), 128'(0));
        chk("midrst_req_out_valid", 128'(req_out.valid), 128'(0));
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive_all_reads();
        model_step();
        run_phase(400, 60, 40, 50, 60, 60);

        @(negedge clk);
        req_in  = '0;
        resp_in = '0;
        repeat (3) @(negedge clk);
        if (rec_q.size() != 0) begin
            errors++;
            $display("FAIL monitor_drain: got %0d pending expected 0", rec_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ami_req_arbiter.md
# ami_req_arbiter

Round-robin arbiter that shares one AMI request/response channel among `NUM_REQ` requesters, such as multiple PU read/write streams feeding a single BlockBuffer `reqIn` port. It registers the winning request onto the shared channel and tracks the owner of every outstanding read in an order FIFO. In-order read responses are then routed back to the requester that issued them.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `REQ_ID_W`, `C_LOG_2(NUM_REQ)`, requester index width
- `MAX_OUTSTANDING`, 16, order-FIFO depth (power of 2)
- `CNT_W`, `C_LOG_2(MAX_OUTSTANDING)+1`, outstanding-count width

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_in[NUM_REQ-1:0]` in AMIRequest: requester requests; `.valid`, `.isWrite` used for arbitration.
- `req_in_grant[NUM_REQ-1:0]` out 1 each: request accepted this cycle.
- `resp_out[NUM_REQ-1:0]` out AMIResponse: routed responses.
- `resp_out_grant[NUM_REQ-1:0]` in 1 each: requester consumes response.
- `req_out` out AMIRequest: registered request to the shared channel.
- `req_out_grant` in 1: downstream accepts `req_out`.
- `resp_in` in AMIResponse: shared-channel response.
- `resp_in_grant` out 1: response consumed.
- `outstanding` out CNT_W: reads issued but not yet answered.
- `err_orphan` out 1: sticky orphan-response flag (only with `AMI_ARB_ERR_EN`).

## Operation
- **Output register.** `req_out` is a single-entry register (`out_full` = `req_out.valid`). The register can load when `!out_full || req_out_grant`.
- **Eligibility.** Requester i is eligible when `req_in[i].valid` and either `req_in[i].isWrite` or the order FIFO is not full. FIFO-full counts a pop in the same cycle, so a pop frees a slot.
- **Arbitration.** Round-robin, starting from `rr_ptr+1` mod `NUM_REQ`. When the register can load and some requester is eligible, the arbiter asserts `req_in_grant[winner]` combinationally, loads `req_in[winner]` into `req_out` at the next edge, and sets `rr_ptr <= winner`.
- **Grant exclusivity.** At most one `req_in_grant` is high per cycle.
- **Read tagging.** A granted read pushes `winner` into the order FIFO. Writes are not tracked (no write response is expected).
- **Response routing.** With the FIFO non-empty and `resp_in.valid`:
  - `resp_out[head]` = `resp_in`.
  - All other `resp_out[j].valid` = 0.
  - `resp_in_grant` = `resp_out_grant[head]`.
  - The FIFO pops on that handshake.
- **Orphan response.** `resp_in.valid` with the FIFO empty is an orphan (behaviour set under Configuration).
- **Outstanding count.** `outstanding` = FIFO occupancy. Simultaneous push and pop leave it unchanged.

## Timing
- **Reset values.** `req_out.valid`=0 and all other `req_out` fields 0, all `req_in_grant`=0, all `resp_out.valid`=0, `resp_in_grant`=0, `outstanding`=0, `err_orphan`=0, `rr_ptr`=`NUM_REQ-1` (so requester 0 has first priority). FIFO pointers clear.
- **Request latency.**
  - Grant on cycle N; `req_out` valid on N+1.
  - Back-to-back grants are sustained at 1 per cycle while `req_out_grant`=1.
  - `req_out` is held stable while `req_out_grant`=0.
- **Response latency.** 0-cycle combinational path from `resp_in` to `resp_out` and from `resp_out_grant` to `resp_in_grant`.
- **FIFO full.** With `outstanding`=`MAX_OUTSTANDING`, reads stall and writes still proceed. If the full FIFO pops in a cycle, a read may be granted in that same cycle.
- **Simultaneous events.** Push and pop in the same cycle are both performed; pointers wrap modulo `MAX_OUTSTANDING`.
- **Mid-operation reset.** `reset` asserted mid-operation discards `req_out` and all outstanding tags immediately (asynchronous). Upstream must also be reset.

## Configuration
- **`AMI_ARB_ERR_EN` defined:**
  - An orphan response sets `err_orphan`=1, which stays set until `reset`.
  - The orphan is consumed (`resp_in_grant`=1) and routed nowhere.
- **`AMI_ARB_ERR_EN` undefined:**
  - The `err_orphan` port is absent.
  - Orphans are not consumed: `resp_in_grant`=0 and the response stays pending until a tag exists.

## Test plan
- **Fairness.** All 4 requesters hold valid reads; `req_out_grant`=1 constantly. Required: grants 0,1,2,3,0,… one per cycle; `outstanding` climbs by 1 per cycle.
- **Backpressure.** Requester 2 write; `req_out_grant`=0 for 5 cycles. Required: `req_out` holds the addr/data unchanged; no further `req_in_grant`; on release, the next grant comes in the same cycle.
- **FIFO full.** 16 reads outstanding; requester 1 read and requester 3 write are pending. Required: only 3 is granted. Then one response is consumed, and in that same cycle requester 1 is granted; `outstanding` stays 16.
- **Routing.** Issue reads from requesters 2, 0, 2; return 3 responses. Required: they appear on `resp_out[2]`, `resp_out[0]`, `resp_out[2]` in order. Holding `resp_out_grant[0]`=0 for 3 cycles holds `resp_in_grant`=0.
- **Orphan.** `resp_in.valid` with the FIFO empty. Required: with `AMI_ARB_ERR_EN`, `err_orphan`=1 next cycle and `resp_in_grant`=1; without it, `resp_in_grant`=0.
- **Mid-operation reset.** Assert `reset` with 5 outstanding reads. Required: `outstanding`=0 and `req_out.valid`=0 immediately; the first grant after reset goes to requester 0.
